// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the writeback stage and register file:
// one-hot status encodings, icode values, the "no register" ID and the
// writeback status FSM state type.
package y86_pkg;

  // Status is carried one-hot with bit 0 as the leftmost bit ([0:3]).
  localparam logic [0:3] STAT_AOK = 4'b1000;
  localparam logic [0:3] STAT_HLT = 4'b0100;
  localparam logic [0:3] STAT_ADR = 4'b0010;
  localparam logic [0:3] STAT_INS = 4'b0001;

  // Instruction codes.
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register ID meaning "no register".
  localparam logic [3:0] RNONE = 4'hF;

  // Architectural status FSM: RUN until the first fault, then sticky.
  typedef enum logic [1:0] {
    ST_RUN,
    ST_HLT,
    ST_ADR,
    ST_INS
  } wbState_t;

  // Terminal state for a non-AOK status; anything not a recognised
  // one-hot code is treated as an illegal instruction.
  function automatic wbState_t faultState(input logic [0:3] s);
    case (s)
      STAT_HLT: faultState = ST_HLT;
      STAT_ADR: faultState = ST_ADR;
      default:  faultState = ST_INS;
    endcase
  endfunction

  // Status value presented while sitting in a given state.
  function automatic logic [0:3] stateStat(input wbState_t st);
    case (st)
      ST_HLT:  stateStat = STAT_HLT;
      ST_ADR:  stateStat = STAT_ADR;
      ST_INS:  stateStat = STAT_INS;
      default: stateStat = STAT_AOK;
    endcase
  endfunction

endpackage

// File: rtl/regfile15.sv
// 15 x 64-bit architectural register file. Two write ports (E and M) share
// one enable; when both target the same register the M port wins, which
// gives popq %rsp its architected result. Three combinational read ports
// return 0 for RNONE. No write-to-read bypass: decode forwards from W.
module regfile15
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [3:0]  i_dstE,
  input  logic [63:0] i_valE,
  input  logic [3:0]  i_dstM,
  input  logic [63:0] i_valM,
  input  logic [3:0]  i_srcA,
  input  logic [3:0]  i_srcB,
  input  logic [3:0]  i_srcDbg,
  output logic [63:0] o_valA,
  output logic [63:0] o_valB,
  output logic [63:0] o_valDbg
);

  logic [63:0] r_regs [0:14];

  // Register array update; the M write is ordered last so it overrides E.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      if (i_dstE != RNONE) r_regs[i_dstE] <= i_valE;
      if (i_dstM != RNONE) r_regs[i_dstM] <= i_valM;
    end
  end

  assign o_valA   = (i_srcA   == RNONE) ? 64'd0 : r_regs[i_srcA];
  assign o_valB   = (i_srcB   == RNONE) ? 64'd0 : r_regs[i_srcB];
  assign o_valDbg = (i_srcDbg == RNONE) ? 64'd0 : r_regs[i_srcDbg];

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: W pipeline register, architectural register file,
// sticky status FSM and retired-instruction counter.
// Build option: define WB_RETIRE_CNT_EN to include the 64-bit retired
// counter; otherwise retired is tied to 0.
module writeback_regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [0:3]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] M_valE,
  input  logic [63:0] m_valM,
  input  logic        W_stall,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  output logic [63:0] d_rvalA,
  output logic [63:0] d_rvalB,
  output logic [0:3]  W_stat,
  output logic [3:0]  W_icode,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [0:3]  stat,
  output logic        halted,
  output logic [63:0] retired,
  input  logic [3:0]  dbg_sel,
  output logic [63:0] dbg_val
);

  logic [0:3]  r_wStat;
  logic [3:0]  r_wIcode;
  logic [3:0]  r_wDstE;
  logic [3:0]  r_wDstM;
  logic [63:0] r_wValE;
  logic [63:0] r_wValM;
  wbState_t    r_state;
  wbState_t    w_nextState;
  logic        w_halted;
  logic        w_wAok;
  logic        w_regWe;

  assign w_halted = (r_state != ST_RUN);
  assign w_wAok   = (r_wStat == STAT_AOK);
  // A faulting instruction never writes, and nothing writes once halted.
  assign w_regWe  = w_wAok && !w_halted;

  // W pipeline register: follows M unless stalled or the machine has stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wStat  <= STAT_AOK;
      r_wIcode <= I_NOP;
      r_wDstE  <= RNONE;
      r_wDstM  <= RNONE;
      r_wValE  <= '0;
      r_wValM  <= '0;
    end else if (!W_stall && !w_halted) begin
      r_wStat  <= M_stat;
      r_wIcode <= M_icode;
      r_wDstE  <= M_dstE;
      r_wDstM  <= M_dstM;
      r_wValE  <= M_valE;
      r_wValM  <= m_valM;
    end
  end

  // Status state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_nextState;
  end

  // Leave RUN on the first non-AOK status in W, regardless of W_stall.
  always_comb begin
    w_nextState = r_state;
    if (r_state == ST_RUN && !w_wAok) begin
      w_nextState = faultState(r_wStat);
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retired;

  // Count real instructions leaving W; bubbles and stalled repeats don't count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_regWe && r_wIcode != I_NOP && !W_stall) begin
      r_retired <= r_retired + 64'd1;
    end
  end

  assign retired = r_retired;
`else
  assign retired = 64'd0;
`endif

  regfile15 u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_regWe),
    .i_dstE   (r_wDstE),
    .i_valE   (r_wValE),
    .i_dstM   (r_wDstM),
    .i_valM   (r_wValM),
    .i_srcA   (d_srcA),
    .i_srcB   (d_srcB),
    .i_srcDbg (dbg_sel),
    .o_valA   (d_rvalA),
    .o_valB   (d_rvalB),
    .o_valDbg (dbg_val)
  );

  assign W_stat  = r_wStat;
  assign W_icode = r_wIcode;
  assign W_dstE  = r_wDstE;
  assign W_dstM  = r_wDstM;
  assign W_valE  = r_wValE;
  assign W_valM  = r_wValM;
  assign stat    = stateStat(r_state);
  assign halted  = w_halted;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: a spec-level model (register
// array, W contents, sticky status, retire count) checked every negedge,
// plus literal expectations at the key points of the scenario.
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic [0:3]  M_stat;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic [63:0] M_valE, m_valM;
  logic        W_stall;
  logic [3:0]  d_srcA, d_srcB, dbg_sel;
  logic [63:0] d_rvalA, d_rvalB, dbg_val;
  logic [0:3]  W_stat;
  logic [3:0]  W_icode, W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  logic [0:3]  stat;
  logic        halted;
  logic [63:0] retired;

  writeback_regfile dut (
    .clk(clk), .rst(rst),
    .M_stat(M_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_valE(M_valE), .m_valM(m_valM), .W_stall(W_stall),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM),
    .stat(stat), .halted(halted), .retired(retired),
    .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;
  bit checkEn = 1'b0;
  int cyc = 0;

  // Behavioural model state.
  logic [63:0] mR [15];
  logic [0:3]  mWstat;
  logic [3:0]  mWicode, mWdstE, mWdstM;
  logic [63:0] mWvalE, mWvalM;
  logic [0:3]  mStat;
  logic [63:0] mRet;

  function automatic logic [63:0] expCnt(input logic [63:0] n);
`ifdef WB_RETIRE_CNT_EN
    return n;
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [63:0] mRead(input logic [3:0] id);
    return (id == 4'hF) ? 64'd0 : mR[id];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 15; i++) mR[i] = 64'd0;
    mWstat = 4'b1000; mWicode = 4'h1; mWdstE = 4'hF; mWdstM = 4'hF;
    mWvalE = 64'd0; mWvalM = 64'd0;
    mStat = 4'b1000; mRet = 64'd0;
  endtask

  // Model: while running, retire the W instruction (or latch its fault),
  // then take the new M values unless stalled. Frozen once stopped.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelReset();
    end else if (mStat == 4'b1000) begin
      if (mWstat == 4'b1000) begin
        if (mWdstE != 4'hF) mR[mWdstE] = mWvalE;
        if (mWdstM != 4'hF) mR[mWdstM] = mWvalM;
        if (mWicode != 4'h1 && !W_stall) mRet = mRet + 64'd1;
      end else begin
        mStat = $onehot(mWstat) ? mWstat : 4'b0001;
      end
      if (!W_stall) begin
        mWstat = M_stat; mWicode = M_icode; mWdstE = M_dstE;
        mWdstM = M_dstM; mWvalE = M_valE; mWvalM = m_valM;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("W_stat",  {60'd0, W_stat},  {60'd0, mWstat});
      checkOutput("W_icode", {60'd0, W_icode}, {60'd0, mWicode});
      checkOutput("W_dstE",  {60'd0, W_dstE},  {60'd0, mWdstE});
      checkOutput("W_dstM",  {60'd0, W_dstM},  {60'd0, mWdstM});
      checkOutput("W_valE",  W_valE, mWvalE);
      checkOutput("W_valM",  W_valM, mWvalM);
      checkOutput("stat",    {60'd0, stat}, {60'd0, mStat});
      checkOutput("halted",  {63'd0, halted}, {63'd0, mStat != 4'b1000});
      checkOutput("retired", retired, expCnt(mRet));
      checkOutput("d_rvalA", d_rvalA, mRead(d_srcA));
      checkOutput("d_rvalB", d_rvalB, mRead(d_srcB));
      checkOutput("dbg_val", dbg_val, mRead(dbg_sel));
    end
  end

  // Present one M-stage instruction and advance one clock edge.
  task automatic applyStimulus(input logic [0:3] s, input logic [3:0] ic,
                               input logic [3:0] dE, input logic [3:0] dM,
                               input logic [63:0] vE, input logic [63:0] vM,
                               input logic st);
    M_stat = s; M_icode = ic; M_dstE = dE; M_dstM = dM;
    M_valE = vE; m_valM = vM; W_stall = st;
    d_srcA = cyc[3:0];
    d_srcB = ~cyc[3:0];
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    applyStimulus(4'b1000, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0);
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulseReset(input logic [3:0] sel);
    dbg_sel = sel;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_dbg_zero", dbg_val, 64'd0);
    checkOutput("rst_stat_aok", {60'd0, stat}, 64'd8);
    checkOutput("rst_W_icode",  {60'd0, W_icode}, 64'd1);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    M_stat = 4'b1000; M_icode = 4'h1; M_dstE = 4'hF; M_dstM = 4'hF;
    M_valE = '0; m_valM = '0; W_stall = 1'b0;
    d_srcA = 4'hF; d_srcB = 4'hF; dbg_sel = 4'hF;
    modelReset();
    #8;
    checkOutput("reset_stat",    {60'd0, stat}, 64'd8);
    checkOutput("reset_W_icode", {60'd0, W_icode}, 64'd1);
    checkOutput("reset_W_dstE",  {60'd0, W_dstE}, 64'hF);
    checkOutput("reset_retired", retired, 64'd0);
    checkOutput("reset_halted",  {63'd0, halted}, 64'd0);
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
    checkEn = 1'b1;

    // irmovq into R3
    applyStimulus(4'b1000, 4'h3, 4'h3, 4'hF, 64'h1234, 64'd0, 1'b0);
    bubble();
    d_srcA = 4'h3;
    #1;
    checkOutput("irmovq_R3", d_rvalA, 64'h1234);
    checkOutput("irmovq_retired", retired, expCnt(64'd1));

    // popq %rsp: M write wins
    applyStimulus(4'b1000, 4'hB, 4'h4, 4'h4, 64'h100, 64'h200, 1'b0);
    bubble();
    dbg_sel = 4'h4;
    #1;
    checkOutput("popq_R4", dbg_val, 64'h200);

    // R5 = 7, then R7 = 0x77 held in W across a 3-cycle stall
    applyStimulus(4'b1000, 4'h3, 4'h5, 4'hF, 64'd7, 64'd0, 1'b0);
    applyStimulus(4'b1000, 4'h3, 4'h7, 4'hF, 64'h77, 64'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1000, 4'h3, 4'h6, 4'hF, 64'h66, 64'd0, 1'b1);
    end
    checkOutput("stall_W_dstE", {60'd0, W_dstE}, 64'h7);
    checkOutput("stall_W_valE", W_valE, 64'h77);
    checkOutput("stall_retired", retired, expCnt(64'd3));
    applyStimulus(4'b1000, 4'h3, 4'h6, 4'hF, 64'h66, 64'd0, 1'b0);
    checkOutput("unstall_W_dstE", {60'd0, W_dstE}, 64'h6);
    bubble();
    dbg_sel = 4'h7;
    #1;
    checkOutput("stall_R7", dbg_val, 64'h77);

    // ADR fault: no write to R2, machine stops, later traffic ignored
    applyStimulus(4'b0010, 4'h5, 4'h2, 4'hF, 64'h999, 64'd0, 1'b0);
    bubble();
    checkOutput("adr_stat", {60'd0, stat}, 64'd2);
    checkOutput("adr_halted", {63'd0, halted}, 64'd1);
    applyStimulus(4'b1000, 4'h3, 4'h9, 4'hF, 64'h9, 64'd0, 1'b0);
    applyStimulus(4'b1000, 4'h3, 4'h9, 4'hF, 64'h9, 64'd0, 1'b0);
    checkOutput("halt_W_icode", {60'd0, W_icode}, 64'd1);
    dbg_sel = 4'h2;
    #1;
    checkOutput("adr_R2", dbg_val, 64'd0);
    dbg_sel = 4'h9;
    #1;
    checkOutput("halt_R9", dbg_val, 64'd0);
    checkOutput("halt_retired", retired, expCnt(64'd5));

    // Asynchronous reset while halted with R5 = 7
    dbg_sel = 4'h5;
    #1;
    checkOutput("pre_rst_R5", dbg_val, 64'd7);
    pulseReset(4'h5);

    // 4 real instructions, 2 bubbles, then HLT
    applyStimulus(4'b1000, 4'h3, 4'h5, 4'hF, 64'h55, 64'd0, 1'b0);
    bubble();
    applyStimulus(4'b1000, 4'h3, 4'h1, 4'hF, 64'h1, 64'd0, 1'b0);
    applyStimulus(4'b1000, 4'h6, 4'h3, 4'hF, 64'h3, 64'd0, 1'b0);
    bubble();
    applyStimulus(4'b1000, 4'h3, 4'h4, 4'hF, 64'h4, 64'd0, 1'b0);
    applyStimulus(4'b0100, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0);
    bubble();
    bubble();
    bubble();
    checkOutput("hlt_stat", {60'd0, stat}, 64'd4);
    checkOutput("hlt_retired", retired, expCnt(64'd4));
    dbg_sel = 4'h5;
    #1;
    checkOutput("resume_R5", dbg_val, 64'h55);

    // Non-one-hot status is treated as INS, with no write
    pulseReset(4'h4);
    applyStimulus(4'b0011, 4'h3, 4'h1, 4'hF, 64'hAB, 64'd0, 1'b0);
    bubble();
    checkOutput("ins_stat", {60'd0, stat}, 64'd1);
    dbg_sel = 4'h1;
    #1;
    checkOutput("ins_R1", dbg_val, 64'd0);

    @(negedge clk);
    #1;
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage and architectural register file for the Y86-64 pipeline, downstream of the memory stage. It holds the W pipeline register and the 15-entry register file, and serves the decode stage's two combinational read ports. It owns the sticky architectural status (AOK/HLT/ADR/INS) that stops the machine, plus an optional retired-instruction counter.

## Interface
- No parameters; all widths are fixed by the ISA.
- clk  in  1  pipeline clock, posedge active
- rst  in  1  asynchronous, active-high reset
- M_stat  in  [0:3]  memory-stage status, one-hot: AOK=1000, HLT=0100, ADR=0010, INS=0001
- M_icode, M_dstE, M_dstM  in  4 each  memory-stage icode and destination IDs; 4'hF = RNONE
- M_valE, m_valM  in  64 each  ALU result and memory read data
- W_stall  in  1  hold the W register (from pipe_control)
- d_srcA, d_srcB  in  4 each  decode read IDs
- d_rvalA, d_rvalB  out  64 each  register contents; 0 when ID = RNONE
- W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM  out  W register contents, for forwarding and pipe control
- stat  out  [0:3]  sticky architectural status
- halted  out  1  high when stat != AOK
- retired  out  64  count of retired non-NOP instructions
- dbg_sel  in  4; dbg_val  out  64  combinational debug read of any register; 0 for RNONE

## Operation
- W register: on posedge, loads the M_* values and m_valM, unless W_stall or halted.
- Register write: on posedge, from the current W contents, only when W_stat == AOK and halted == 0.
  - R[W_dstE] <= W_valE if W_dstE != F.
  - R[W_dstM] <= W_valM if W_dstM != F.
  - If W_dstE == W_dstM != F, W_valM wins (popq %rsp rule).
- Writes are not blocked by W_stall. A stalled W performs the same idempotent write again.
- Reads (d_rvalA, d_rvalB, dbg_val) are purely combinational from the array. There is no internal write-to-read bypass; decode forwards from W.
- Status FSM states:
  - RUN: stat = AOK.
  - HLT, ADR, INS: terminal and sticky.
  - Transition: on posedge in RUN, if W_stat != AOK, enter the state matching W_stat and latch stat = W_stat.
  - The faulting instruction performs no register write.
  - If W_stat is not one-hot, treat it as INS.
- Retired counter:
  - +1 on each posedge in RUN with W_stat == AOK, W_icode != 1 (NOP/bubble), and W_stall == 0.
  - Wraps modulo 2^64.

## Timing
- Reset values: all R = 0, W_stat = AOK, W_icode = 1, W_dstE = W_dstM = F, W_valE = W_valM = 0, stat = AOK, halted = 0, retired = 0.
- Latency:
  - M to W outputs: 1 cycle.
  - M to register visible on d_rval: 2 cycles (W edge, then write edge).
  - Non-AOK in W to halted: 1 edge.
- Reset asserted mid-operation clears everything immediately (async), independent of clk. On deassertion, operation resumes at the next posedge.
- A simultaneous W_stall and fault in W still transitions the FSM on that edge.
- Once halted, the W register, register file and counter are frozen until rst.

## Configuration
- WB_RETIRE_CNT_EN
  - Defined: the 64-bit counter is built as specified.
  - Undefined: the counter is removed and retired is tied to 0.
  - The rest of the block's behaviour is identical in both builds.

## Structure
- Shared package y86_pkg holds:
  - stat encodings: STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS
  - icode constants: I_NOP = 1 and the rest
  - RNONE = 4'hF
  - FSM state typedef
- One sub-module, regfile15: 15x64 array with the dual write and priority rule, plus three combinational read ports.
- The W register, FSM and counter live in writeback_regfile.

## Test plan
- Reset, then W carries irmovq (dstE = 3, valE = 0x1234) -> next edge R3 = 0x1234, d_rvalA(srcA = 3) = 0x1234, retired = 1.
- popq %rsp: W_dstE = W_dstM = 4, valE = 0x100, valM = 0x200 -> R4 = 0x200.
- W_stall held 3 cycles with a new M_* presented -> W outputs unchanged. M values appear one edge after the stall drops; retired does not increment during the stall.
- W_stat = ADR with dstE = 2 -> R2 unchanged, stat = 0010, halted = 1. Later AOK M traffic never alters W or registers.
- W_stat = HLT after 4 non-NOP instructions and 2 bubbles -> stat = 0100, retired = 4. With WB_RETIRE_CNT_EN undefined -> retired = 0.
- Assert rst between edges while halted with R5 = 7 -> immediately R5 = 0, stat = AOK, W_icode = 1, and normal writes resume after deassertion.
